// File: rtl/fraction_div_sqrt_unit.sv
// Iterative radix-2 restoring divide / square-root engine for the FPU mantissa path.
// One result bit per cycle through a single shared subtractor; one operation in flight.
module fraction_div_sqrt_unit #(
  parameter int FRAC_WIDTH = 24,
  parameter int QUOT_WIDTH = 27,
  parameter int REM_WIDTH  = 27
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [2:0]            op_in,
  input  logic [9:0]            exp_in,
  input  logic [FRAC_WIDTH-1:0] dividend,
  input  logic [FRAC_WIDTH-1:0] divisor,
  input  logic                  sqrt_odd,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [2:0]            op_out,
  output logic [9:0]            exp_out,
  output logic [QUOT_WIDTH-1:0] quotient,
  output logic [REM_WIDTH-1:0]  remainder
);

  localparam int RW = QUOT_WIDTH + 2;
  localparam int MW = 2 * QUOT_WIDTH;
  localparam int CW = $clog2(QUOT_WIDTH);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t                state;
  logic [CW-1:0]         count;
  logic [RW-1:0]         rem_q;
  logic [QUOT_WIDTH-1:0] quot_q;
  logic [MW-1:0]         mant_q;
  logic [FRAC_WIDTH-1:0] div_b;
  logic                  is_sqrt;
  logic                  div_zero;

  logic [RW-1:0]         minuend;
  logic [RW-1:0]         subtrahend;
  logic [RW:0]           diff;
  logic                  fits;
  logic [RW-1:0]         kept;
  logic [QUOT_WIDTH-1:0] quot_next;
  logic [REM_WIDTH-1:0]  rem_fmt;

  assign in_ready = (state == IDLE);

  // Shared subtractor: sqrt brings in the next two radicand bits and tries 4q+1,
  // divide tries the divisor against the current partial remainder.
  always_comb begin
    minuend    = rem_q;
    subtrahend = {{(RW-FRAC_WIDTH){1'b0}}, div_b};
    if (is_sqrt) begin
      minuend    = {rem_q[RW-3:0], mant_q[MW-1:MW-2]};
      subtrahend = {quot_q, 2'b01};
    end
    diff      = {1'b0, minuend} - {1'b0, subtrahend};
    fits      = ~diff[RW];
    kept      = fits ? diff[RW-1:0] : minuend;
    quot_next = {quot_q[QUOT_WIDTH-2:0], fits};
    rem_fmt   = kept[REM_WIDTH-1:0];
    if (is_sqrt) begin
      rem_fmt = {|kept[RW-1:REM_WIDTH-1], kept[REM_WIDTH-2:0]};
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      count     <= '0;
      rem_q     <= '0;
      quot_q    <= '0;
      mant_q    <= '0;
      div_b     <= '0;
      is_sqrt   <= 1'b0;
      div_zero  <= 1'b0;
      out_valid <= 1'b0;
      op_out    <= '0;
      exp_out   <= '0;
      quotient  <= '0;
      remainder <= '0;
    end else if (flush) begin
      state     <= IDLE;
      count     <= '0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            state    <= BUSY;
            count    <= CW'(QUOT_WIDTH - 1);
            op_out   <= op_in;
            exp_out  <= exp_in;
            quot_q   <= '0;
            div_b    <= divisor;
            is_sqrt  <= (op_in == 3'd4);
            div_zero <= (op_in != 3'd4) && !divisor[FRAC_WIDTH-1];
            if (op_in == 3'd4) begin
              rem_q <= '0;
            end else begin
              rem_q <= {{(RW-FRAC_WIDTH){1'b0}}, dividend};
            end
            if (sqrt_odd) begin
              mant_q <= {dividend, 1'b0, {(MW-FRAC_WIDTH-1){1'b0}}};
            end else begin
              mant_q <= {1'b0, dividend, {(MW-FRAC_WIDTH-1){1'b0}}};
            end
          end
        end
        BUSY: begin
          quot_q <= quot_next;
          if (is_sqrt) begin
            rem_q  <= kept;
            mant_q <= mant_q << 2;
          end else if (count != '0) begin
            rem_q <= kept << 1;
          end else begin
            rem_q <= kept;
          end
          if (count == '0) begin
            state     <= DONE;
            out_valid <= 1'b1;
            quotient  <= div_zero ? '1 : quot_next;
            remainder <= div_zero ? '0 : rem_fmt;
          end else begin
            count <= count - 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fraction_div_sqrt_unit.sv
// Self-checking bench for fraction_div_sqrt_unit: integer-arithmetic reference model,
// per-cycle monitor, directed corner cases and randomized operands.
module tb_fraction_div_sqrt_unit;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  op_in;
  logic [9:0]  exp_in;
  logic [23:0] dividend;
  logic [23:0] divisor;
  logic        sqrt_odd;
  logic        out_valid;
  logic        out_ready;
  logic [2:0]  op_out;
  logic [9:0]  exp_out;
  logic [26:0] quotient;
  logic [26:0] remainder;

  int     checkCount = 0;
  int     passCount  = 0;
  longint cycle      = 0;

  typedef struct {
    logic [26:0] q;
    logic [26:0] r;
    logic [2:0]  op;
    logic [9:0]  ex;
    longint      edgeNum;
  } expect_t;

  expect_t model[$];
  expect_t entry;

  fraction_div_sqrt_unit dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op_in     (op_in),
    .exp_in    (exp_in),
    .dividend  (dividend),
    .divisor   (divisor),
    .sqrt_odd  (sqrt_odd),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .op_out    (op_out),
    .exp_out   (exp_out),
    .quotient  (quotient),
    .remainder (remainder)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checkCount++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, actual, expected, cycle);
  endtask

  // Divide: q = floor(a*2^26 / b), remainder is what is left over
  function automatic void refDiv(input logic [23:0] a, input logic [23:0] b,
                                 output logic [26:0] q, output logic [26:0] r);
    longint unsigned num, qq, rr;
    if (!b[23]) begin
      q = '1;
      r = '0;
    end else begin
      num = longint'(a) << 26;
      qq  = num / longint'(b);
      rr  = num % longint'(b);
      q   = qq[26:0];
      r   = rr[26:0];
    end
  endfunction

  // Sqrt: integer root of the radicand scaled to 2^52, remainder M - q^2
  function automatic void refSqrt(input logic [23:0] x, input logic odd,
                                  output logic [26:0] q, output logic [26:0] r);
    longint unsigned m, root, cand, rr;
    m    = odd ? (longint'(x) << 30) : (longint'(x) << 29);
    root = 0;
    for (int b = 26; b >= 0; b--) begin
      cand = root | (64'd1 << b);
      if (cand * cand <= m) root = cand;
    end
    rr = m - root * root;
    q  = root[26:0];
    r  = {|rr[28:26], rr[25:0]};
  endfunction

  function automatic expect_t makeEntry(input logic [2:0] op, input logic [9:0] ex,
                                        input logic [23:0] a, input logic [23:0] b,
                                        input logic odd, input longint edgeNum);
    expect_t e;
    if (op == 3'd4) refSqrt(a, odd, e.q, e.r);
    else refDiv(a, b, e.q, e.r);
    e.op      = op;
    e.ex      = ex;
    e.edgeNum = edgeNum;
    return e;
  endfunction

  // Per-cycle monitor: exact out_valid timing, in_ready, and result fields while valid
  always @(negedge clk) begin
    logic expValid;
    logic accept;
    if (!reset_n) model.delete();
    expValid = (model.size() > 0) && (cycle >= model[0].edgeNum + 27);
    checkOutput("mon_out_valid", out_valid, expValid);
    checkOutput("mon_in_ready", in_ready, model.size() == 0);
    if (expValid) begin
      checkOutput("mon_quotient", quotient, model[0].q);
      checkOutput("mon_remainder", remainder, model[0].r);
      checkOutput("mon_op_out", op_out, model[0].op);
      checkOutput("mon_exp_out", exp_out, model[0].ex);
    end
    if (reset_n) begin
      accept = in_valid && (model.size() == 0) && !flush;
      if (flush) model.delete();
      else if (expValid && out_ready) void'(model.pop_front());
      if (accept) begin
        entry = makeEntry(op_in, exp_in, dividend, divisor, sqrt_odd, cycle + 1);
        model.push_back(entry);
      end
    end
  end

  task automatic applyStimulus(input logic [2:0] op, input logic [9:0] ex,
                               input logic [23:0] a, input logic [23:0] b, input logic odd,
                               input int stall, input bit pulse,
                               output logic [26:0] q, output logic [26:0] r,
                               output logic [2:0] opo, output logic [9:0] exo,
                               output int lat);
    longint start;
    @(posedge clk); #1;
    op_in = op; exp_in = ex; dividend = a; divisor = b; sqrt_odd = odd;
    in_valid  = 1'b1;
    out_ready = (stall == 0);
    start = cycle;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = -1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (out_valid) begin
        lat = int'(cycle - (start + 1));
        break;
      end
    end
    checkOutput("result_arrives", out_valid, 1'b1);
    q = quotient; r = remainder; opo = op_out; exo = exp_out;
    for (int i = 0; i < stall; i++) begin
      @(posedge clk); #1;
      if (pulse) begin
        in_valid = i[0];
        dividend = 24'($urandom);
        op_in    = 3'($urandom);
        exp_in   = 10'($urandom);
      end
      @(negedge clk);
      checkOutput("stall_out_valid", out_valid, 1'b1);
      checkOutput("stall_quotient", quotient, q);
      checkOutput("stall_op_out", op_out, opo);
      checkOutput("stall_exp_out", exp_out, exo);
      checkOutput("stall_in_ready", in_ready, 1'b0);
    end
    @(posedge clk); #1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    if (stall > 0) begin
      @(posedge clk); #1;
      checkOutput("in_ready_after_drain", in_ready, 1'b1);
    end
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [26:0] q, r, mq, mr;
    logic [2:0]  opo;
    logic [9:0]  exo;
    int          lat;
    logic [2:0]  rop;
    logic [23:0] ra, rb;

    reset_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    op_in = '0; exp_in = '0; dividend = '0; divisor = '0; sqrt_odd = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_in_ready", in_ready, 1'b1);
    checkOutput("reset_out_valid", out_valid, 1'b0);
    checkOutput("reset_quotient", quotient, 27'h0);
    reset_n = 1'b1;

    refDiv(24'h800000, 24'hC00000, mq, mr);
    checkOutput("model_div_1_over_1p5", mq, 27'h2AAAAAA);
    refSqrt(24'h800000, 1'b1, mq, mr);
    checkOutput("model_sqrt2", mq, 27'h5A82799);
    refSqrt(24'h800000, 1'b0, mq, mr);
    checkOutput("model_sqrt1_rem", mr, 27'h0);

    applyStimulus(3'd3, 10'h101, 24'h800000, 24'h800000, 1'b0, 0, 1'b0, q, r, opo, exo, lat);
    checkOutput("div_1_1_quotient", q, 27'h4000000);
    checkOutput("div_1_1_remainder", r, 27'h0);
    checkOutput("div_1_1_latency", lat, 27);

    applyStimulus(3'd3, 10'h102, 24'h800000, 24'hC00000, 1'b0, 0, 1'b0, q, r, opo, exo, lat);
    checkOutput("div_1_1p5_quotient", q, 27'h2AAAAAA);
    checkOutput("div_1_1p5_rem_nonzero", r != 0, 1'b1);

    applyStimulus(3'd4, 10'h103, 24'h800000, 24'h0, 1'b0, 0, 1'b0, q, r, opo, exo, lat);
    checkOutput("sqrt_1_quotient", q, 27'h4000000);
    checkOutput("sqrt_1_remainder", r, 27'h0);

    applyStimulus(3'd4, 10'h104, 24'h800000, 24'h0, 1'b1, 0, 1'b0, q, r, opo, exo, lat);
    checkOutput("sqrt_2_quotient", q, 27'h5A82799);
    checkOutput("sqrt_2_rem_nonzero", r != 0, 1'b1);
    checkOutput("sqrt_2_op_out", opo, 3'd4);

    applyStimulus(3'd3, 10'h105, 24'hABCDEF, 24'h123456, 1'b0, 0, 1'b0, q, r, opo, exo, lat);
    checkOutput("div_by_zero_quotient", q, 27'h7FFFFFF);
    checkOutput("div_by_zero_remainder", r, 27'h0);
    checkOutput("div_by_zero_latency", lat, 27);

    applyStimulus(3'd3, 10'h2AA, 24'hE00000, 24'hA00000, 1'b0, 5, 1'b1, q, r, opo, exo, lat);
    checkOutput("stall_exp_captured", exo, 10'h2AA);

    // Reset in the middle of an operation
    @(posedge clk); #1;
    op_in = 3'd3; exp_in = 10'h055; dividend = 24'hF00000; divisor = 24'h900000;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1 reset_n = 1'b0;
    #1;
    checkOutput("midreset_out_valid", out_valid, 1'b0);
    checkOutput("midreset_in_ready", in_ready, 1'b1);
    checkOutput("midreset_exp_out", exp_out, 10'h0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    applyStimulus(3'd3, 10'h0AB, 24'h800000, 24'hC00000, 1'b0, 0, 1'b0, q, r, opo, exo, lat);
    checkOutput("post_reset_quotient", q, 27'h2AAAAAA);

    // Flush mid-operation, then flush racing a new request in IDLE
    @(posedge clk); #1;
    op_in = 3'd3; exp_in = 10'h17F; dividend = 24'hC00000; divisor = 24'h800000;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    checkOutput("flush_in_ready", in_ready, 1'b1);
    flush = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    checkOutput("flush_wins_in_ready", in_ready, 1'b1);
    repeat (30) @(posedge clk);
    applyStimulus(3'd5, 10'h201, 24'h900000, 24'h800000, 1'b0, 0, 1'b0, q, r, opo, exo, lat);
    checkOutput("post_flush_op_out", opo, 3'd5);
    checkOutput("post_flush_exp_out", exo, 10'h201);
    checkOutput("post_flush_quotient", q, 27'h4800000);

    // Randomized operands; the monitor compares every result against the model
    for (int n = 0; n < 30; n++) begin
      case ($urandom_range(0, 2))
        0: rop = 3'd3;
        1: rop = 3'd4;
        default: rop = 3'($urandom);
      endcase
      ra = 24'($urandom) | 24'h800000;
      rb = 24'($urandom);
      if ($urandom_range(0, 7) != 0) rb = rb | 24'h800000;
      applyStimulus(rop, 10'($urandom), ra, rb, 1'($urandom), int'($urandom_range(0, 3)), 1'b0,
                    q, r, opo, exo, lat);
      checkOutput("rand_latency", lat, 27);
    end

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
